// File: rtl/player_stats.sv
// Player status: life FSM with invulnerability window, saturating money with a spend
// handshake, and a scanned 4-digit seven-segment money readout fed by a serial BCD converter.
module player_stats #(
    parameter int unsigned LIFE_MAX      = 10,
    parameter int unsigned MONEY_MAX     = 9999,
    parameter int unsigned MONEY_W       = 14,
    parameter int unsigned HIT_REWARD    = 1,
    parameter int unsigned INVULN_CYCLES = 50000000,
    parameter int unsigned SCAN_DIV      = 100000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          damage,
    input  logic                          heal,
    input  logic                          hit,
    input  logic                          spend_req,
    input  logic [MONEY_W-1:0]            spend_amt,
    output logic                          spend_ack,
    output logic                          spend_nack,
    output logic [$clog2(LIFE_MAX+1)-1:0] life_cnt,
    output logic [LIFE_MAX-1:0]           life_bar,
    output logic                          invuln,
    output logic                          dead,
    output logic [MONEY_W-1:0]            money,
    output logic [6:0]                    display,
    output logic [3:0]                    digit
);

    localparam int unsigned LC_W   = $clog2(LIFE_MAX + 1);
    localparam int unsigned TMR_W  = (INVULN_CYCLES > 1) ? $clog2(INVULN_CYCLES) : 1;
    localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned CNT_W  = (MONEY_W > 1) ? $clog2(MONEY_W) : 1;
    localparam int unsigned SUM_W  = MONEY_W + 1;

    localparam logic [LC_W-1:0]   LifeFull = LC_W'(LIFE_MAX);
    localparam logic [TMR_W-1:0]  TmrLoad  = TMR_W'(INVULN_CYCLES - 1);
    localparam logic [SCAN_W-1:0] ScanLast = SCAN_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]  CntLast  = CNT_W'(MONEY_W - 1);
    localparam logic [SUM_W-1:0]  HitAdd   = SUM_W'(HIT_REWARD);
    localparam logic [SUM_W-1:0]  MoneyCap = SUM_W'(MONEY_MAX);

    localparam logic [6:0] SegD     = 7'b0100001;
    localparam logic [6:0] SegE     = 7'b0000110;
    localparam logic [6:0] SegA     = 7'b0001000;
    localparam logic [6:0] SegBlank = 7'b1111111;

    typedef enum logic [1:0] {StAlive, StInvuln, StDead} state_e;

    state_e             state_q, state_d;
    logic [LC_W-1:0]    life_q, life_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [MONEY_W-1:0] money_q, money_d;
    logic               ack_d, nack_d;
    logic [SUM_W-1:0]   sum;

    // Life / invulnerability FSM
    always_comb begin
        state_d = state_q;
        life_d  = life_q;
        tmr_d   = tmr_q;
        unique case (state_q)
            StAlive: begin
                if (damage) begin
                    if (life_q <= LC_W'(1)) begin
                        life_d  = '0;
                        state_d = StDead;
                    end else begin
                        life_d  = life_q - LC_W'(1);
                        tmr_d   = TmrLoad;
                        state_d = StInvuln;
                    end
                end else if (heal && life_q < LifeFull) begin
                    life_d = life_q + LC_W'(1);
                end
            end
            StInvuln: begin
                if (heal && life_q < LifeFull) life_d = life_q + LC_W'(1);
                if (tmr_q == '0) state_d = StAlive;
                else             tmr_d   = tmr_q - TMR_W'(1);
            end
            StDead: begin
            end
            default: state_d = StAlive;
        endcase
    end

    // Spend is judged against the pre-hit balance; the hit reward lands afterwards.
    always_comb begin
        money_d = money_q;
        ack_d   = 1'b0;
        nack_d  = 1'b0;
        sum     = {1'b0, money_q};
        if (state_q == StDead) begin
            nack_d = spend_req;
        end else begin
            if (spend_req) begin
                if (spend_amt <= money_q) begin
                    sum   = {1'b0, money_q - spend_amt};
                    ack_d = 1'b1;
                end else begin
                    nack_d = 1'b1;
                end
            end
            if (hit) sum = sum + HitAdd;
            money_d = (sum > MoneyCap) ? MoneyCap[MONEY_W-1:0] : sum[MONEY_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StAlive;
            life_q     <= LifeFull;
            tmr_q      <= '0;
            money_q    <= '0;
            spend_ack  <= 1'b0;
            spend_nack <= 1'b0;
        end else begin
            state_q    <= state_d;
            life_q     <= life_d;
            tmr_q      <= tmr_d;
            money_q    <= money_d;
            spend_ack  <= ack_d;
            spend_nack <= nack_d;
        end
    end

    // Double-dabble: one bit per cycle; changes seen mid-conversion re-trigger via pend_q.
    logic               chg_q, pend_q, busy_q, start;
    logic [CNT_W-1:0]   cnt_q;
    logic [MONEY_W-1:0] sh_bin_q, bin_nx;
    logic [15:0]        sh_bcd_q, bcd_nx, adj, bcd_q;

    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            adj[4*i +: 4] = (sh_bcd_q[4*i +: 4] >= 4'd5) ? sh_bcd_q[4*i +: 4] + 4'd3
                                                         : sh_bcd_q[4*i +: 4];
        end
        {bcd_nx, bin_nx} = {adj[14:0], sh_bin_q, 1'b0};
        start = !busy_q && (chg_q || pend_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chg_q    <= 1'b0;
            pend_q   <= 1'b0;
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            sh_bin_q <= '0;
            sh_bcd_q <= '0;
            bcd_q    <= '0;
        end else begin
            chg_q <= (money_d != money_q);
            if (start) begin
                busy_q   <= 1'b1;
                pend_q   <= 1'b0;
                cnt_q    <= '0;
                sh_bin_q <= money_q;
                sh_bcd_q <= '0;
            end else if (busy_q) begin
                sh_bin_q <= bin_nx;
                sh_bcd_q <= bcd_nx;
                if (chg_q) pend_q <= 1'b1;
                if (cnt_q == CntLast) begin
                    busy_q <= 1'b0;
                    bcd_q  <= bcd_nx;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    end

    // Display scan
    logic [SCAN_W-1:0] scan_q;
    logic [1:0]        sel_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_q <= '0;
            sel_q  <= '0;
        end else if (scan_q == ScanLast) begin
            scan_q <= '0;
            sel_q  <= sel_q + 2'd1;
        end else begin
            scan_q <= scan_q + SCAN_W'(1);
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = SegBlank;
        endcase
    endfunction

    logic [3:0] nib;
    logic       blank;
    logic [6:0] dead_glyph;

    always_comb begin
        nib        = bcd_q[3:0];
        blank      = 1'b0;
        dead_glyph = SegD;
        unique case (sel_q)
            2'd0: begin
                nib        = bcd_q[3:0];
                dead_glyph = SegD;
            end
            2'd1: begin
                nib        = bcd_q[7:4];
                blank      = (bcd_q[15:4] == '0);
                dead_glyph = SegA;
            end
            2'd2: begin
                nib        = bcd_q[11:8];
                blank      = (bcd_q[15:8] == '0);
                dead_glyph = SegE;
            end
            2'd3: begin
                nib        = bcd_q[15:12];
                blank      = (bcd_q[15:12] == '0);
                dead_glyph = SegD;
            end
        endcase
        digit = ~(4'b0001 << sel_q);
        if (state_q == StDead) display = dead_glyph;
        else if (blank)        display = SegBlank;
        else                   display = seg7(nib);
    end

    always_comb begin
        for (int unsigned i = 0; i < LIFE_MAX; i++) begin
            life_bar[i] = (LC_W'(i) < life_q);
        end
    end

    assign life_cnt = life_q;
    assign money    = money_q;
    assign invuln   = (state_q == StInvuln);
    assign dead     = (state_q == StDead);

endmodule

// File: tb/tb_player_stats.sv
// Directed bench for player_stats with LIFE_MAX=4, INVULN_CYCLES=8, SCAN_DIV=4.
module tb_player_stats;

    logic        clk = 1'b0;
    logic        rst, damage, heal, hit, spend_req;
    logic [13:0] spend_amt;
    logic        spend_ack, spend_nack, invuln, dead;
    logic [2:0]  life_cnt;
    logic [3:0]  life_bar;
    logic [13:0] money;
    logic [6:0]  display;
    logic [3:0]  digit;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    player_stats #(
        .LIFE_MAX     (4),
        .MONEY_MAX    (9999),
        .MONEY_W      (14),
        .HIT_REWARD   (1),
        .INVULN_CYCLES(8),
        .SCAN_DIV     (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .damage    (damage),
        .heal      (heal),
        .hit       (hit),
        .spend_req (spend_req),
        .spend_amt (spend_amt),
        .spend_ack (spend_ack),
        .spend_nack(spend_nack),
        .life_cnt  (life_cnt),
        .life_bar  (life_bar),
        .invuln    (invuln),
        .dead      (dead),
        .money     (money),
        .display   (display),
        .digit     (digit)
    );

    task automatic do_reset;
        rst = 1'b1; damage = 1'b0; heal = 1'b0; hit = 1'b0; spend_req = 1'b0; spend_amt = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic hits(input int n);
        hit = 1'b1;
        repeat (n) @(negedge clk);
        hit = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        tests++; if (life_cnt !== 3'd4) begin fails++; $display("FAIL reset_life got %0d want 4", life_cnt); end
        tests++; if (life_bar !== 4'b1111) begin fails++; $display("FAIL reset_bar got %b want 1111", life_bar); end
        tests++; if (money !== 14'd0) begin fails++; $display("FAIL reset_money got %0d want 0", money); end
        tests++; if ({invuln, dead, spend_ack, spend_nack} !== 4'b0000) begin
            fails++; $display("FAIL reset_flags got %b want 0000", {invuln, dead, spend_ack, spend_nack}); end
        tests++; if (digit !== 4'b1110) begin fails++; $display("FAIL reset_digit got %b want 1110", digit); end
        tests++; if (display !== 7'b1000000) begin fails++; $display("FAIL reset_display got %b want 1000000", display); end
    endtask

    task automatic test_async_reset;
        do_reset();
        hits(37);
        damage = 1'b1; @(negedge clk); damage = 1'b0;
        tests++; if ({invuln, money} !== {1'b1, 14'd37}) begin
            fails++; $display("FAIL pre_reset got invuln=%b money=%0d want 1/37", invuln, money); end
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        tests++; if ({life_cnt, life_bar} !== {3'd4, 4'b1111}) begin
            fails++; $display("FAIL async_life got %0d/%b want 4/1111", life_cnt, life_bar); end
        tests++; if ({invuln, money} !== {1'b0, 14'd0}) begin
            fails++; $display("FAIL async_money got invuln=%b money=%0d want 0/0", invuln, money); end
        tests++; if ({digit, display} !== {4'b1110, 7'b1000000}) begin
            fails++; $display("FAIL async_disp got %b/%b want 1110/1000000", digit, display); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_invuln;
        int inv_cnt;
        do_reset();
        damage = 1'b1; @(negedge clk); damage = 1'b0;
        tests++; if (life_cnt !== 3'd3) begin fails++; $display("FAIL inv_first got %0d want 3", life_cnt); end
        inv_cnt = invuln ? 1 : 0;
        for (int k = 1; k <= 8; k++) begin
            damage = (k == 3);  // lands at t0+3
            @(negedge clk);
            damage = 1'b0;
            if (invuln) inv_cnt++;
        end
        tests++; if (inv_cnt !== 8) begin fails++; $display("FAIL inv_len got %0d want 8", inv_cnt); end
        tests++; if ({invuln, life_cnt} !== {1'b0, 3'd3}) begin
            fails++; $display("FAIL inv_ignored got invuln=%b life=%0d want 0/3", invuln, life_cnt); end
        damage = 1'b1; @(negedge clk); damage = 1'b0;
        tests++; if ({invuln, life_cnt} !== {1'b1, 3'd2}) begin
            fails++; $display("FAIL inv_second got invuln=%b life=%0d want 1/2", invuln, life_cnt); end
        heal = 1'b1; repeat (3) @(negedge clk); heal = 1'b0;
        tests++; if ({invuln, life_cnt, life_bar} !== {1'b1, 3'd4, 4'b1111}) begin
            fails++; $display("FAIL heal_sat got invuln=%b life=%0d bar=%b want 1/4/1111", invuln, life_cnt, life_bar); end
        repeat (10) @(negedge clk);
        damage = 1'b1; heal = 1'b1; @(negedge clk); damage = 1'b0; heal = 1'b0;
        tests++; if (life_cnt !== 3'd3) begin fails++; $display("FAIL dmg_heal got %0d want 3", life_cnt); end
    endtask

    task automatic test_dead;
        logic [3:0] prev;
        logic [3:0] seen;
        logic [6:0] exp;
        do_reset();
        repeat (4) begin
            damage = 1'b1; @(negedge clk); damage = 1'b0;
            repeat (9) @(negedge clk);
        end
        tests++; if ({dead, invuln, life_cnt, life_bar} !== {1'b1, 1'b0, 3'd0, 4'b0000}) begin
            fails++; $display("FAIL dead_state got dead=%b inv=%b life=%0d bar=%b want 1/0/0/0000",
                              dead, invuln, life_cnt, life_bar); end
        prev = digit;
        seen = ~digit;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            case (digit)
                4'b1110: exp = 7'b0100001;
                4'b1101: exp = 7'b0001000;
                4'b1011: exp = 7'b0000110;
                4'b0111: exp = 7'b0100001;
                default: exp = 7'b1111111;
            endcase
            tests++; if (display !== exp) begin
                fails++; $display("FAIL dead_glyph digit=%b got %b want %b", digit, display, exp); end
            if (digit !== prev) begin
                tests++; if (digit !== {prev[2:0], prev[3]}) begin
                    fails++; $display("FAIL scan_order got %b want %b", digit, {prev[2:0], prev[3]}); end
            end
            prev = digit;
            seen = seen | ~digit;
        end
        tests++; if (seen !== 4'b1111) begin fails++; $display("FAIL dead_seen got %b want 1111", seen); end
        hit = 1'b1; heal = 1'b1; repeat (3) @(negedge clk); hit = 1'b0; heal = 1'b0;
        tests++; if ({money, life_cnt} !== {14'd0, 3'd0}) begin
            fails++; $display("FAIL dead_ignore got money=%0d life=%0d want 0/0", money, life_cnt); end
        spend_req = 1'b1; spend_amt = 14'd0; @(negedge clk); spend_req = 1'b0;
        tests++; if ({spend_ack, spend_nack} !== 2'b01) begin
            fails++; $display("FAIL dead_spend got ack/nack=%b want 01", {spend_ack, spend_nack}); end
    endtask

    task automatic test_spend;
        do_reset();
        hits(5);
        tests++; if (money !== 14'd5) begin fails++; $display("FAIL spend_pre got %0d want 5", money); end
        spend_req = 1'b1; spend_amt = 14'd7; hit = 1'b1; @(negedge clk); spend_req = 1'b0; hit = 1'b0;
        tests++; if ({spend_ack, spend_nack, money} !== {2'b01, 14'd6}) begin
            fails++; $display("FAIL spend_refuse got ack/nack=%b money=%0d want 01/6", {spend_ack, spend_nack}, money); end
        @(negedge clk);
        tests++; if ({spend_ack, spend_nack} !== 2'b00) begin
            fails++; $display("FAIL spend_pulse got %b want 00", {spend_ack, spend_nack}); end
        spend_req = 1'b1; spend_amt = 14'd6; @(negedge clk); spend_req = 1'b0;
        tests++; if ({spend_ack, spend_nack, money} !== {2'b10, 14'd0}) begin
            fails++; $display("FAIL spend_accept got ack/nack=%b money=%0d want 10/0", {spend_ack, spend_nack}, money); end
        spend_req = 1'b1; spend_amt = 14'd0; @(negedge clk); spend_req = 1'b0;
        tests++; if ({spend_ack, spend_nack, money} !== {2'b10, 14'd0}) begin
            fails++; $display("FAIL spend_zero got ack/nack=%b money=%0d want 10/0", {spend_ack, spend_nack}, money); end
    endtask

    task automatic test_saturate;
        logic [3:0] seen;
        do_reset();
        hits(9998);
        tests++; if (money !== 14'd9998) begin fails++; $display("FAIL sat_pre got %0d want 9998", money); end
        hits(3);
        tests++; if (money !== 14'd9999) begin fails++; $display("FAIL sat_money got %0d want 9999", money); end
        repeat (50) @(negedge clk);
        seen = 4'b0000;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            tests++; if (display !== 7'b0010000) begin
                fails++; $display("FAIL sat_digit digit=%b got %b want 0010000", digit, display); end
            seen = seen | ~digit;
        end
        tests++; if (seen !== 4'b1111) begin fails++; $display("FAIL sat_seen got %b want 1111", seen); end
    endtask

    task automatic test_back_to_back;
        logic [6:0] exp;
        do_reset();
        hits(5);
        tests++; if (money !== 14'd5) begin fails++; $display("FAIL b2b_money got %0d want 5", money); end
        repeat (50) @(negedge clk);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            exp = (digit == 4'b1110) ? 7'b0010010 : 7'b1111111;
            tests++; if (display !== exp) begin
                fails++; $display("FAIL b2b_disp digit=%b got %b want %b", digit, display, exp); end
        end
    endtask

    initial begin
        rst = 1'b1; damage = 1'b0; heal = 1'b0; hit = 1'b0; spend_req = 1'b0; spend_amt = '0;
        test_reset();
        test_async_reset();
        test_invuln();
        test_dead();
        test_spend();
        test_saturate();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/player_stats.md
Name: player_stats

Overview:
- Parametrised player-status block: life counter with invulnerability window and death state, saturating money counter with a spend handshake, and a 4-digit multiplexed seven-segment readout of money.
- Money is converted by a sequential binary-to-BCD engine; no dividers.
- Sits between the game-event logic (damage/heal/hit/spend pulses) and the board LEDs and seven-segment display.

Parameters:
- LIFE_MAX, 10, full life points; width of the life_bar output.
- MONEY_MAX, 9999, money saturation value; must be ≤ 9999.
- MONEY_W, 14, money width in bits.
- HIT_REWARD, 1, money added per hit.
- INVULN_CYCLES, 50000000, number of cycles the block stays invulnerable after non-fatal damage.
- SCAN_DIV, 100000, clk cycles each display digit stays enabled.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- damage  in  1  one-cycle pulse: lose 1 life.
- heal  in  1  one-cycle pulse: gain 1 life.
- hit  in  1  one-cycle pulse: gain HIT_REWARD money.
- spend_req  in  1  one-cycle pulse: purchase request.
- spend_amt  in  MONEY_W  purchase price, sampled when spend_req=1.
- spend_ack  out  1  registered one-cycle pulse: purchase accepted.
- spend_nack  out  1  registered one-cycle pulse: purchase refused.
- life_cnt  out  $clog2(LIFE_MAX+1)  current life.
- life_bar  out  LIFE_MAX  thermometer code; the low life_cnt bits are set.
- invuln  out  1  high in the INVULN state.
- dead  out  1  high in the DEAD state.
- money  out  MONEY_W  current money, binary.
- display  out  7  segments, active-low; bit0=a … bit6=g.
- digit  out  4  digit enables, active-low; bit0 = ones digit.

Behaviour:
- Reset (asynchronous, immediate):
  - life_cnt=LIFE_MAX, life_bar all ones, state ALIVE.
  - money=0, BCD register=0, spend_ack=spend_nack=0.
  - scan counter=0, digit=4'b1110, display=7'b1000000 ("0").
  - A conversion in progress is aborted.
- FSM states: ALIVE, INVULN, DEAD.
  - ALIVE, damage:
    - life_cnt=1 → life_cnt=0, go to DEAD.
    - otherwise → life_cnt−1, load the invuln timer with INVULN_CYCLES−1, go to INVULN.
  - INVULN: damage is ignored. The timer decrements each cycle; the cycle after it reads 0 → ALIVE. invuln is therefore high for exactly INVULN_CYCLES cycles.
  - DEAD: terminal until rst. damage, heal and hit are ignored. Every spend_req gets spend_nack.
- heal (ALIVE or INVULN): life_cnt+1, saturating at LIFE_MAX. heal does not change state or the invuln timer.
- damage and heal in the same cycle while ALIVE: damage is applied and heal is dropped. In INVULN, heal applies and damage is ignored.
- Money (ALIVE or INVULN):
  - spend_req is evaluated against the money value before this cycle's hit.
  - Accept when spend_amt ≤ money: next = min(money − spend_amt + (hit ? HIT_REWARD : 0), MONEY_MAX).
  - Refuse when spend_amt > money: next = min(money + (hit ? HIT_REWARD : 0), MONEY_MAX).
  - spend_ack or spend_nack is asserted for exactly one cycle, the cycle after spend_req, together with the updated money.
  - spend_amt=0 is always accepted.
- BCD engine:
  - Shift-and-add-3 (double-dabble), one bit per cycle.
  - A conversion starts the cycle after the money register changes. It snapshots money and finishes in MONEY_W cycles, then the 4-digit BCD register updates atomically.
  - If money changes during a conversion: the current conversion completes, then a pending flag starts a new conversion on the next cycle. The final BCD value always equals the final money.
- Display scan:
  - The scan counter advances the active digit every SCAN_DIV cycles in the order ones → tens → hundreds → thousands → ones.
  - Leading zeros are blanked (display=7'b1111111); the ones digit is never blanked.
  - When dead=1, the display shows "dEAd" (thousands..ones) instead of money.
  - Segment codes:
    - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
    - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
    - d=0100001, E=0000110, A=0001000

Test Plan:
- Use LIFE_MAX=4, INVULN_CYCLES=8, SCAN_DIV=4.
- Reset mid-INVULN with money=37 → in the same cycle: life_cnt=4, life_bar=1111, money=0, invuln=0, digit=1110, display=1000000.
- damage at t0 → life_cnt=3 and invuln=1 for exactly 8 cycles. A damage pulse at t0+3 is ignored. A damage at t0+9 → life_cnt=2.
- Four damage pulses spaced 10 cycles apart → life_cnt=0 and dead=1; the display cycles d,A,E,d on ones/tens/hundreds/thousands. Afterwards, hit and heal have no effect and spend_req → spend_nack.
- Money=5; spend_req with spend_amt=7 and hit in the same cycle → spend_nack, money=6. Then spend_amt=6 → spend_ack, money=0.
- Money=9998; 3 hit pulses → money=9999 (saturated). 14 cycles later the BCD register reads 9,9,9,9 and all four digits light.
- hit pulses on consecutive cycles (money 0→5) → a conversion restarts after completion. Final display shows "5" on ones only; tens, hundreds and thousands are blank.
